// File: rtl/controlador_venda.sv
// Sale controller for a vending machine: latches the product price, gates coins
// to the accumulator, triggers the comparator and drives the dispense/refund pulses.
module controlador_venda #(
   parameter int T_LIMITE = 50,
   parameter int T_PULSO  = 4
) (
   input  logic       CLK,
   input  logic       rst,
   input  logic [1:0] sel,
   input  logic       escolher,
   input  logic       confirma,
   input  logic       cancela,
   input  logic [1:0] VM_in,
   input  logic       LP,
   input  logic       DM,
   input  logic [3:0] vTotal,
   output logic [1:0] VM,
   output logic [2:0] vProduto,
   output logic       TL,
   output logic       rstA,
   output logic       rstC,
   output logic       liberar,
   output logic       devolver,
   output logic [3:0] troco,
   output logic       ocupado
);

   typedef enum logic [2:0] {
      LIMPA, IDLE, SELECIONADO, DISPARA, ESPERA, LIBERA, DEVOLVE
   } estado_t;

   localparam logic [7:0] TIMER_FIM = 8'(T_LIMITE - 1);
   localparam logic [3:0] PULSO_FIM = 4'(T_PULSO - 1);

   estado_t    estado_q, estado_d;
   logic [7:0] timer_q, timer_d;
   logic [3:0] cont_q, cont_d;
   logic [2:0] preco_q, preco_d;
   logic [3:0] troco_q, troco_d;
   logic [3:0] preco_ext;
   logic [3:0] sobra;

   function automatic logic [2:0] preco_de(input logic [1:0] s);
      case (s)
         2'b00:   return 3'd3;
         2'b01:   return 3'd4;
         2'b10:   return 3'd5;
         default: return 3'd7;
      endcase
   endfunction

   // Change never goes negative: underpayment with LP asserted yields zero.
   assign preco_ext = {1'b0, preco_q};
   assign sobra     = (vTotal >= preco_ext) ? (vTotal - preco_ext) : 4'd0;

   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         estado_q <= LIMPA;
         timer_q  <= '0;
         cont_q   <= '0;
         preco_q  <= '0;
         troco_q  <= '0;
      end else begin
         estado_q <= estado_d;
         timer_q  <= timer_d;
         cont_q   <= cont_d;
         preco_q  <= preco_d;
         troco_q  <= troco_d;
      end
   end

   always_comb begin
      estado_d = estado_q;
      timer_d  = timer_q;
      cont_d   = cont_q;
      preco_d  = preco_q;
      troco_d  = troco_q;
      unique case (estado_q)
         LIMPA: estado_d = IDLE;
         IDLE: begin
            if (escolher) begin
               preco_d  = preco_de(sel);
               timer_d  = '0;
               estado_d = SELECIONADO;
            end
         end
         SELECIONADO: begin
            timer_d = (VM_in != 2'b00) ? 8'd0 : timer_q + 8'd1;
            // A coin on the expiry cycle keeps the sale open.
            if (cancela) begin
               troco_d  = vTotal;
               cont_d   = '0;
               estado_d = DEVOLVE;
            end else if (confirma || (VM_in == 2'b00 && timer_q == TIMER_FIM)) begin
               estado_d = DISPARA;
            end
         end
         DISPARA: begin
            cont_d   = '0;
            estado_d = ESPERA;
         end
         ESPERA: begin
            if (LP) begin
               troco_d  = sobra;
               cont_d   = '0;
               estado_d = LIBERA;
            end else if (DM || cont_q == 4'd1) begin
               troco_d  = vTotal;
               cont_d   = '0;
               estado_d = DEVOLVE;
            end else begin
               cont_d = cont_q + 4'd1;
            end
         end
         LIBERA, DEVOLVE: begin
            if (cont_q == PULSO_FIM) begin
               troco_d  = '0;
               estado_d = LIMPA;
            end else begin
               cont_d = cont_q + 4'd1;
            end
         end
         default: estado_d = LIMPA;
      endcase
   end

   always_comb begin
      VM       = (estado_q == SELECIONADO) ? VM_in : 2'b00;
      vProduto = preco_q;
      troco    = troco_q;
      TL       = (estado_q == DISPARA);
      rstA     = (estado_q == LIMPA);
      rstC     = (estado_q == LIMPA);
      liberar  = (estado_q == LIBERA);
      devolver = (estado_q == DEVOLVE);
      ocupado  = (estado_q != IDLE);
   end

endmodule

// File: tb/tb_controlador_venda.sv
// Directed bench for controlador_venda: stimulus pushes expected sales into a
// scoreboard, a monitor pops one entry per dispense/refund pulse.
module tb_controlador_venda;

   localparam int T_LIMITE = 50;
   localparam int T_PULSO  = 4;

   logic       CLK = 1'b0;
   logic       rst;
   logic [1:0] sel;
   logic       escolher, confirma, cancela;
   logic [1:0] VM_in;
   logic       LP, DM;
   logic [3:0] vTotal;
   logic [1:0] VM;
   logic [2:0] vProduto;
   logic       TL, rstA, rstC, liberar, devolver, ocupado;
   logic [3:0] troco;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int kind;   // 1 = liberar, 2 = devolver
      int troco;
      int len;
      int tl;
   } exp_t;

   exp_t sb_q[$];

   controlador_venda #(.T_LIMITE(T_LIMITE), .T_PULSO(T_PULSO)) dut (
      .CLK(CLK), .rst(rst), .sel(sel), .escolher(escolher), .confirma(confirma),
      .cancela(cancela), .VM_in(VM_in), .LP(LP), .DM(DM), .vTotal(vTotal),
      .VM(VM), .vProduto(vProduto), .TL(TL), .rstA(rstA), .rstC(rstC),
      .liberar(liberar), .devolver(devolver), .troco(troco), .ocupado(ocupado)
   );

   always #5 CLK = ~CLK;

   // Accumulator stand-in: sums gated coins, cleared by rstA.
   always @(posedge CLK) begin
      if (rstA) vTotal <= 4'd0;
      else      vTotal <= vTotal + {2'b00, VM};
   end

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic push(input int kind, input int tr, input int len, input int tl);
      exp_t e;
      e.kind = kind; e.troco = tr; e.len = len; e.tl = tl;
      sb_q.push_back(e);
   endtask

   task automatic coin(input logic [1:0] v);
      VM_in = v;
      #1;
      chk("vm_pass", int'(VM), int'(v));
      step();
      VM_in = 2'b00;
   endtask

   task automatic pulse_escolher(input logic [1:0] s);
      sel = s; escolher = 1'b1;
      step();
      escolher = 1'b0;
   endtask

   task automatic wait_tl(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!TL && n < 200);
   endtask

   task automatic wait_idle(input string name);
      int n, limpa;
      n = 0; limpa = 0;
      do begin
         step();
         n++;
         if (rstA) limpa++;
      end while (ocupado && n < 60);
      chk({name, "_idle"}, int'(ocupado), 0);
      chk({name, "_limpa_cycles"}, limpa, 1);
      LP = 1'b0; DM = 1'b0;
   endtask

   // Monitor: one scoreboard pop per dispense/refund pulse.
   initial begin
      bit   in_pulse = 0;
      int   cur_kind = 0, cur_troco = 0, cur_len = 0, tl_cnt = 0;
      exp_t e;
      forever begin
         @(negedge CLK);
         if (TL) tl_cnt++;
         if (liberar || devolver) begin
            if (!in_pulse) begin
               in_pulse  = 1;
               cur_kind  = int'({devolver, liberar});
               cur_troco = int'(troco);
               cur_len   = 1;
            end else begin
               cur_len++;
               if (int'({devolver, liberar}) != cur_kind) cur_kind = 3;
            end
         end else if (in_pulse) begin
            in_pulse = 0;
            $display("sale kind=%0d troco=%0d len=%0d tl=%0d", cur_kind, cur_troco, cur_len, tl_cnt);
            if (sb_q.size() == 0) begin
               chk("unexpected_sale", 1, 0);
            end else begin
               e = sb_q.pop_front();
               chk("sale_kind", cur_kind, e.kind);
               chk("sale_troco", cur_troco, e.troco);
               chk("sale_len", cur_len, e.len);
               chk("sale_tl", tl_cnt, e.tl);
            end
            tl_cnt = 0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b1; sel = 2'b00; escolher = 1'b0; confirma = 1'b0; cancela = 1'b0;
      VM_in = 2'b10; LP = 1'b0; DM = 1'b0;
      repeat (3) step();
      chk("rst_rstA", int'(rstA), 1);
      chk("rst_rstC", int'(rstC), 1);
      chk("rst_ocupado", int'(ocupado), 1);
      chk("rst_outs", int'({TL, liberar, devolver}), 0);
      chk("rst_troco", int'(troco), 0);
      chk("rst_vProduto", int'(vProduto), 0);
      chk("rst_vm", int'(VM), 0);
      VM_in = 2'b00;
      rst = 1'b0;
      #1;
      chk("release_limpa", int'(rstA), 1);
      step();
      chk("release_idle", int'(ocupado), 0);
      chk("release_rstA", int'(rstA), 0);

      // Strobes in IDLE other than escolher do nothing; coins are rejected.
      confirma = 1'b1; cancela = 1'b1; VM_in = 2'b11;
      #1;
      chk("idle_coin_vm", int'(VM), 0);
      step();
      confirma = 1'b0; cancela = 1'b0; VM_in = 2'b00;
      chk("idle_strobes", int'(ocupado), 0);

      // Price 4, coins 2+2, confirma, LP -> liberar, troco 0.
      push(1, 0, T_PULSO, 1);
      pulse_escolher(2'b01);
      chk("sel01_price", int'(vProduto), 4);
      coin(2'b10); coin(2'b10);
      confirma = 1'b1; step(); confirma = 1'b0;
      LP = 1'b1;
      wait_idle("sale1");

      // Price 7, coins 2x4, timeout exactly T_LIMITE edges after last coin.
      push(1, 1, T_PULSO, 1);
      pulse_escolher(2'b11);
      chk("sel11_price", int'(vProduto), 7);
      coin(2'b10); coin(2'b10); coin(2'b10); coin(2'b10);
      wait_tl(n);
      chk("timeout_latency", n, T_LIMITE);
      LP = 1'b1;
      wait_idle("sale2");

      // Price 5, coin 2, cancela -> refund 2, no TL; escolher ignored mid-sale.
      push(2, 2, T_PULSO, 0);
      pulse_escolher(2'b10);
      pulse_escolher(2'b00);
      chk("escolher_ignored", int'(vProduto), 5);
      coin(2'b10);
      step();
      cancela = 1'b1; step(); cancela = 1'b0;
      wait_idle("sale3");

      // Coin on the expiry cycle reloads the timer; comparator silent -> refund.
      push(2, 1, T_PULSO, 1);
      pulse_escolher(2'b00);
      repeat (T_LIMITE - 1) step();
      VM_in = 2'b01;
      #1;
      chk("expiry_coin_vm", int'(VM), 1);
      step();
      VM_in = 2'b00;
      chk("expiry_no_tl", int'(TL), 0);
      chk("expiry_still_busy", int'(ocupado), 1);
      wait_tl(n);
      chk("reload_latency", n, T_LIMITE);
      n = 0;
      do begin step(); n++; end while (!devolver && n < 10);
      chk("espera_failsafe_cycles", n, 3);
      wait_idle("sale4");

      // DM verdict -> refund of vTotal.
      push(2, 1, T_PULSO, 1);
      pulse_escolher(2'b01);
      coin(2'b01);
      confirma = 1'b1; step(); confirma = 1'b0;
      DM = 1'b1;
      wait_idle("sale5");

      // LP and DM together: LP wins, change 6-4.
      push(1, 2, T_PULSO, 1);
      pulse_escolher(2'b01);
      coin(2'b11); coin(2'b11);
      confirma = 1'b1; step(); confirma = 1'b0;
      LP = 1'b1; DM = 1'b1;
      wait_idle("sale6");

      // Underpayment with LP: change saturates at 0.
      push(1, 0, T_PULSO, 1);
      pulse_escolher(2'b11);
      coin(2'b11);
      confirma = 1'b1; step(); confirma = 1'b0;
      LP = 1'b1;
      wait_idle("sale7");

      // cancela and confirma together: cancela wins.
      push(2, 2, T_PULSO, 0);
      pulse_escolher(2'b01);
      coin(2'b10);
      cancela = 1'b1; confirma = 1'b1; step(); cancela = 1'b0; confirma = 1'b0;
      wait_idle("sale8");

      // Reset during LIBERA truncates the pulse after two cycles.
      push(1, 3, 2, 1);
      pulse_escolher(2'b00);
      coin(2'b11); coin(2'b11);
      confirma = 1'b1; step(); confirma = 1'b0;
      LP = 1'b1;
      n = 0;
      do begin step(); n++; end while (!liberar && n < 10);
      chk("liberar_seen", int'(liberar), 1);
      step(); step();
      rst = 1'b1;
      #1;
      chk("midrst_liberar", int'(liberar), 0);
      chk("midrst_rstA", int'(rstA), 1);
      chk("midrst_rstC", int'(rstC), 1);
      chk("midrst_troco", int'(troco), 0);
      chk("midrst_vProduto", int'(vProduto), 0);
      LP = 1'b0;
      step(); step();
      rst = 1'b0;
      #1;
      chk("midrst_release_limpa", int'(rstA), 1);
      step();
      chk("midrst_idle", int'(ocupado), 0);

      repeat (3) step();
      chk("scoreboard_empty", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
